// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
//
// Purpose:
//   Bundles the instruction-memory request/ack bus, the fetch->decode
//   valid/ready slot and the redirect inputs of the fetch sequencer.
//
// Signal summary:
//   imem_req        sequencer -> memory   fetch request
//   imem_addr[31:0] sequencer -> memory   fetch address, stable while imem_req=1
//   imem_ack        memory -> sequencer   current request completes this cycle
//   imem_rdata[31:0]memory -> sequencer   instruction word, valid with imem_ack
//   if_valid        sequencer -> decode   slot holds a valid instruction
//   if_pc[31:0]     sequencer -> decode   PC of the slot instruction
//   if_instr[31:0]  sequencer -> decode   slot instruction
//   if_ready        decode -> sequencer   decode accepts the slot this cycle
//   redirect_valid  core -> sequencer     branch/jump taken
//   redirect_target core -> sequencer     new PC (bits [1:0] ignored)
//   exc_valid       core -> sequencer     exception request   (FETCH_EXC_EN)
//   exc_pc[31:0]    core -> sequencer     faulting PC to save (FETCH_EXC_EN)
//   epc[31:0]       sequencer -> core     saved exception PC  (FETCH_EXC_EN)
//
// Modports:
//   master  the fetch sequencer side
//   slave   the environment side (memory, decode and branch unit)
//
// Optional feature macro: FETCH_EXC_EN adds the exception signals.
// ----------------------------------------------------------------------------
interface fetch_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    logic        redirect_valid;
    logic [31:0] redirect_target;

`ifdef FETCH_EXC_EN
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [31:0] epc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_pc, if_instr,
        input  if_ready,
        input  redirect_valid, redirect_target,
        input  exc_valid, exc_pc,
        output epc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_pc, if_instr,
        output if_ready,
        output redirect_valid, redirect_target,
        output exc_valid, exc_pc,
        input  epc
    );
`else
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_pc, if_instr,
        input  if_ready,
        input  redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_pc, if_instr,
        output if_ready,
        output redirect_valid, redirect_target
    );
`endif

endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Owns the program counter of the MIPS datapath, issues instruction fetches
//   to instruction memory with a req/ack handshake, presents each fetched
//   instruction to decode through a one-entry valid/ready slot and applies
//   branch/jump redirects, including redirects that arrive while a fetch is
//   still outstanding (the in-flight result is then squashed).
//
// Parameters:
//   RESET_VECTOR  PC loaded on reset
//   PC_STEP       sequential PC increment in bytes
//   EXC_VECTOR    exception handler address (FETCH_EXC_EN only)
//
// Ports:
//   clock   in  system clock, all state updates on the rising edge
//   reset   in  asynchronous reset, active low (asserted when 0)
//   bus     fetch_sequencer_if.master: memory bus, decode slot, redirect
//           inputs and (with FETCH_EXC_EN) exception request / saved EPC
//
// Optional feature macro: FETCH_EXC_EN
//   Adds exc_valid / exc_pc / epc. An exception outranks redirect and ack in
//   every state, saves exc_pc into epc and redirects fetch to EXC_VECTOR.
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4
`ifdef FETCH_EXC_EN
    ,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    fetch_sequencer_if.master    bus
);

    // BOOT  : one idle cycle after reset before the first request
    // FETCH : request outstanding, result will be delivered
    // DRAIN : request outstanding, result will be discarded (redirect pending)
    // FULL  : slot holds an instruction waiting for decode
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } state_t;

    localparam logic [31:0] PC_INC = 32'(PC_STEP);

    state_t      state,       state_next;
    logic [31:0] pc,          pc_next;
    logic        slot_valid,  slot_valid_next;
    logic [31:0] slot_pc,     slot_pc_next;
    logic [31:0] slot_instr,  slot_instr_next;
    logic        redir_pend,  redir_pend_next;
    logic [31:0] redir_tgt,   redir_tgt_next;
`ifdef FETCH_EXC_EN
    logic [31:0] epc_q,       epc_next;
`endif

    // Unified control-flow change request: an exception (if enabled) or a
    // redirect, with the target already word aligned.
    logic        jump;
    logic [31:0] jump_tgt;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = bus.redirect_target & ~32'h0000_0003;

    // The memory address always mirrors the PC; while a request is
    // outstanding the PC is frozen (pending redirects go to redir_tgt),
    // which keeps imem_addr stable until the ack.
    assign bus.imem_req  = (state == FETCH) || (state == DRAIN);
    assign bus.imem_addr = pc;
    assign bus.if_valid  = slot_valid;
    assign bus.if_pc     = slot_pc;
    assign bus.if_instr  = slot_instr;
`ifdef FETCH_EXC_EN
    assign bus.epc       = epc_q;
`endif

    // State register: all sequential state, asynchronously cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            slot_valid <= 1'b0;
            slot_pc    <= 32'h0;
            slot_instr <= 32'h0;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'h0;
`ifdef FETCH_EXC_EN
            epc_q      <= 32'h0;
`endif
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            slot_valid <= slot_valid_next;
            slot_pc    <= slot_pc_next;
            slot_instr <= slot_instr_next;
            redir_pend <= redir_pend_next;
            redir_tgt  <= redir_tgt_next;
`ifdef FETCH_EXC_EN
            epc_q      <= epc_next;
`endif
        end
    end

    // Next-state logic: every register holds by default, then the current
    // state decides what the handshake and redirect inputs change.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        slot_valid_next = slot_valid;
        slot_pc_next    = slot_pc;
        slot_instr_next = slot_instr;
        redir_pend_next = redir_pend;
        redir_tgt_next  = redir_tgt;
        jump            = bus.redirect_valid;
        jump_tgt        = redirect_aligned;
`ifdef FETCH_EXC_EN
        epc_next        = epc_q;
        // Exception wins over a simultaneous redirect, which is dropped.
        if (bus.exc_valid) begin
            jump     = 1'b1;
            jump_tgt = EXC_VECTOR;
            epc_next = bus.exc_pc;
        end
`endif

        case (state)
            BOOT: begin
                if (jump) begin
                    pc_next = jump_tgt;
                end
                state_next = FETCH;
            end

            FETCH: begin
                if (bus.imem_ack) begin
                    if (jump) begin
                        // Result arrives together with a redirect: drop it
                        // and refetch from the target next cycle.
                        pc_next = jump_tgt;
                    end else begin
                        slot_valid_next = 1'b1;
                        slot_pc_next    = pc;
                        slot_instr_next = bus.imem_rdata;
                        pc_next         = pc + PC_INC;
                        state_next      = FULL;
                    end
                end else if (jump) begin
                    // The address must not move under an outstanding
                    // request, so the target waits in redir_tgt.
                    redir_pend_next = 1'b1;
                    redir_tgt_next  = jump_tgt;
                    state_next      = DRAIN;
                end
            end

            DRAIN: begin
                if (bus.imem_ack) begin
                    if (jump) begin
                        pc_next = jump_tgt;
                    end else if (redir_pend) begin
                        pc_next = redir_tgt;
                    end
                    redir_pend_next = 1'b0;
                    state_next      = FETCH;
                end else if (jump) begin
                    redir_tgt_next = jump_tgt;
                end
            end

            FULL: begin
                if (jump) begin
                    slot_valid_next = 1'b0;
                    pc_next         = jump_tgt;
                    state_next      = FETCH;
                end else if (bus.if_ready) begin
                    slot_valid_next = 1'b0;
                    state_next      = FETCH;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program counter and instruction-fetch side of the MIPS datapath.
- Owns the PC register and handles the req/ack handshake with instruction memory.
- Hands fetched instructions to decode through a valid/ready slot.
- Applies branch/jump redirects, including redirects that arrive while a memory fetch is still in flight.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.
- EXC_VECTOR, 32'h0000_0080, exception handler address; used only with FETCH_EXC_EN.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ack  in  1  memory completes the current request this cycle.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- if_valid  out  1  instruction slot holds a valid instruction.
- if_pc  out  32  PC of the instruction in the slot.
- if_instr  out  32  instruction in the slot.
- if_ready  in  1  decode accepts the slot this cycle.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  32  new PC; bits [1:0] forced to 00.
- exc_valid  in  1  exception request (FETCH_EXC_EN only).
- exc_pc  in  32  faulting PC to save (FETCH_EXC_EN only).
- epc  out  32  saved exception PC (FETCH_EXC_EN only).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=BOOT, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR.
  - if_valid=0, if_pc=0, if_instr=0, redir_pend=0, epc=0.
- Outputs imem_req and imem_addr are combinational from state and pc.
  - imem_req=1 exactly in FETCH and DRAIN.
  - imem_addr=pc.
- BOOT: next cycle → FETCH.
- FETCH: request outstanding.
  - imem_ack=1, no redirect: if_instr=imem_rdata, if_pc=pc, if_valid=1, pc=pc+PC_STEP (modulo 2^32, so 32'hFFFF_FFFC → 0), then → FULL.
  - imem_ack=0 with redirect_valid=1: must not change imem_addr. Latch redir_pend=1 and redir_tgt, then → DRAIN.
  - imem_ack=1 and redirect_valid=1 in the same cycle: discard rdata, pc=target, stay in FETCH (new address next cycle).
- DRAIN: a request whose result is squashed is still outstanding.
  - A further redirect overwrites redir_tgt (last one wins).
  - On imem_ack: discard rdata, pc=redir_tgt (or the same-cycle redirect target if one arrives), redir_pend=0, → FETCH.
- FULL: imem_req=0, if_valid=1, if_pc/if_instr held stable.
  - if_ready=1: if_valid=0, → FETCH.
  - redirect_valid=1: if_valid=0, pc=target, → FETCH. Redirect wins over if_ready; the slot is flushed either way.
- if_valid is never 1 in FETCH, DRAIN or BOOT.
- A redirect always clears if_valid in the same edge.
- Latency:
  - Zero-wait memory gives an ack→if_valid delay of 1 cycle.
  - Accepting the slot starts the next request on the following cycle.
  - Peak throughput: 1 instruction per 2 cycles.
- A redirect in BOOT loads pc=target; BOOT still proceeds to FETCH.
- Reset asserted mid-fetch abandons the request immediately (imem_req=0). Memory must tolerate req dropping without an ack.

Optional Feature:
- Macro: FETCH_EXC_EN.
- Defined:
  - Adds the exc_valid, exc_pc and epc ports.
  - exc_valid has the highest priority, above redirect and ack, in every state.
  - On exc_valid: epc=exc_pc, if_valid=0, target=EXC_VECTOR, using the same rules as a redirect. In FETCH with no ack, this means DRAIN with redir_tgt=EXC_VECTOR.
  - Simultaneous exc_valid and redirect_valid: the exception wins and the redirect is dropped.
- Not defined: these ports and epc are absent; behaviour is exactly as above.

Test Plan:
- Release reset, memory acks every request in the same cycle, if_ready=1: imem_addr sequence 0,4,8,C; if_pc matches with if_valid pulses; if_instr equals rdata.
- Hold if_ready=0 for 5 cycles after the first instruction: if_valid, if_pc=0 and if_instr held stable; imem_req=0 throughout; fetch of 4 starts the cycle after if_ready=1.
- Memory delays ack 3 cycles; pulse redirect_valid with target 0x100 in the 1st wait cycle: imem_addr stays 0x8 until ack; that data is never presented; next imem_addr=0x100.
- Redirect to 0x40 and then 0x80 during the same DRAIN: only 0x80 is fetched. Redirect coincident with ack: data dropped, next address is the target.
- Set pc near 0xFFFFFFFC via redirect: next sequential fetch address is 0x00000000.
- With FETCH_EXC_EN: exc_valid (exc_pc=0x24) together with redirect_valid (0x200) → epc=0x24, next fetch 0x80, redirect ignored. Assert reset mid-wait → imem_req=0 and pc=RESET_VECTOR immediately.
